// File: rtl/timer_set_editor.sv
// Button front end for the countdown timer: edits an HH:MM:SS BCD preset with
// auto-repeat and field blink, and issues one-cycle set/play/stop/reset commands.
module timer_set_editor #(
  parameter int HOLD_CYCLES   = 2500000,
  parameter int REPEAT_CYCLES = 500000,
  parameter int BLINK_CYCLES  = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       btn_start_stop,
  input  logic       counting,
  input  logic       ring,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic [1:0] field_sel,
  output logic       editing,
  output logic       blink,
  output logic       set_out,
  output logic       play_out,
  output logic       stop_out,
  output logic       reset_out
);

  localparam int RW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_RELOAD = RW'(HOLD_CYCLES - REPEAT_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);

  // Button vector order: 0 mode, 1 up, 2 down, 3 confirm, 4 start_stop.
  typedef enum logic [1:0] {IDLE = 2'd0, EDIT_H = 2'd1, EDIT_M = 2'd2, EDIT_S = 2'd3} state_t;

  state_t        state;
  logic [4:0]    btn_cur;
  logic [4:0]    btn_prev;
  logic [4:0]    press;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_cnt_next;
  logic [BW-1:0] blink_cnt;
  logic          held_one;
  logic          rep_hit;
  logic          step_up;
  logic          step_down;
  logic [7:0]    field_val;
  logic [7:0]    field_max;
  logic [7:0]    field_new;

  // Expired status needs no action here; confirm in idle already clears it.
  logic ring_unused;
  assign ring_unused = ring;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)              return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)            return max;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    else                       return v - 8'd1;
  endfunction

  always_comb begin
    press     = btn_cur & ~btn_prev;
    held_one  = btn_cur[1] ^ btn_cur[2];
    rep_hit   = (rep_cnt == HOLD_LAST);
    step_up   = btn_cur[1] & ~btn_cur[2] & (press[1] | rep_hit);
    step_down = btn_cur[2] & ~btn_cur[1] & (press[2] | rep_hit);
    if (!held_one || press[1] || press[2]) rep_cnt_next = '0;
    else if (rep_hit)                      rep_cnt_next = HOLD_RELOAD;
    else                                   rep_cnt_next = rep_cnt + 1'b1;
    case (state)
      EDIT_H:  begin field_val = hour_bcd;   field_max = 8'h23; end
      EDIT_M:  begin field_val = minute_bcd; field_max = 8'h59; end
      default: begin field_val = second_bcd; field_max = 8'h59; end
    endcase
    if (step_up)        field_new = bcd_inc(field_val, field_max);
    else if (step_down) field_new = bcd_dec(field_val, field_max);
    else                field_new = field_val;
  end

  assign field_sel = state;
  assign editing   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      btn_cur    <= '0;
      btn_prev   <= '0;
      rep_cnt    <= '0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
      hour_bcd   <= 8'h00;
      minute_bcd <= 8'h00;
      second_bcd <= 8'h10;
      set_out    <= 1'b0;
      play_out   <= 1'b0;
      stop_out   <= 1'b0;
      reset_out  <= 1'b0;
    end else begin
      btn_prev  <= btn_cur;
      btn_cur   <= {btn_start_stop, btn_confirm, btn_down, btn_up, btn_mode};
      set_out   <= 1'b0;
      play_out  <= 1'b0;
      stop_out  <= 1'b0;
      reset_out <= 1'b0;
      if (state == IDLE) begin
        rep_cnt   <= '0;
        blink_cnt <= '0;
        blink     <= 1'b0;
        if (press[3]) begin
          reset_out <= 1'b1;
        end else if (press[0] && !counting) begin
          state <= EDIT_H;
          blink <= 1'b1;
        end else if (press[4]) begin
          if (counting) stop_out <= 1'b1;
          else          play_out <= 1'b1;
        end
      end else if (counting || press[3]) begin
        // A running timer abandons the edit; confirm commits it.
        set_out   <= press[3] & ~counting;
        state     <= IDLE;
        rep_cnt   <= '0;
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else begin
        if (blink_cnt == BLINK_LAST) begin
          blink     <= ~blink;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
        if (press[0]) begin
          rep_cnt <= '0;
          case (state)
            EDIT_H:  state <= EDIT_M;
            EDIT_M:  state <= EDIT_S;
            default: state <= EDIT_H;
          endcase
        end else begin
          rep_cnt <= rep_cnt_next;
          case (state)
            EDIT_H:  hour_bcd   <= field_new;
            EDIT_M:  minute_bcd <= field_new;
            default: second_bcd <= field_new;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_set_editor.sv
// Directed bench for timer_set_editor: table of single button presses plus
// hand-written auto-repeat, blink, reset-mid-edit and abort sequences.
module tb_timer_set_editor;
  localparam int HOLD  = 10;
  localparam int REP   = 4;
  localparam int BLINK = 6;

  localparam logic [4:0] B_MODE = 5'b00001;
  localparam logic [4:0] B_UP   = 5'b00010;
  localparam logic [4:0] B_DOWN = 5'b00100;
  localparam logic [4:0] B_CONF = 5'b01000;
  localparam logic [4:0] B_SS   = 5'b10000;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_SET  = 4'b1000;
  localparam logic [3:0] P_PLAY = 4'b0100;
  localparam logic [3:0] P_STOP = 4'b0010;
  localparam logic [3:0] P_RST  = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_confirm = 1'b0, btn_start_stop = 1'b0;
  logic counting = 1'b0, ring = 1'b0;
  logic [7:0] hour_bcd, minute_bcd, second_bcd;
  logic [1:0] field_sel;
  logic editing, blink, set_out, play_out, stop_out, reset_out;

  timer_set_editor #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_confirm(btn_confirm), .btn_start_stop(btn_start_stop),
    .counting(counting), .ring(ring),
    .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .field_sel(field_sel), .editing(editing), .blink(blink),
    .set_out(set_out), .play_out(play_out), .stop_out(stop_out), .reset_out(reset_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    logic       cnt;
    logic       rng;
    logic [1:0] field;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [3:0] pulse;
  } vec_t;

  vec_t vecs[22];
  int pass_cnt = 0;
  int total_cnt = 0;
  logic cap_blink;
  logic [30:0] s1, s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [30:0] snap();
    return {field_sel, hour_bcd, minute_bcd, second_bcd, set_out, play_out, stop_out, reset_out, editing};
  endfunction

  function automatic logic [30:0] expect_snap(input logic [1:0] f, input logic [7:0] h, input logic [7:0] m,
                                              input logic [7:0] s, input logic [3:0] p);
    return {f, h, m, s, p, (f != 2'd0)};
  endfunction

  task automatic drive(input logic [4:0] b);
    {btn_start_stop, btn_confirm, btn_down, btn_up, btn_mode} = b;
  endtask

  // One-cycle press; s1 is sampled after the acting edge, s2 one cycle later.
  task automatic press(input logic [4:0] b, output logic [30:0] a1, output logic [30:0] a2);
    @(negedge clk); drive(b);
    @(negedge clk); drive(5'b0);
    @(posedge clk); #1 a1 = snap(); cap_blink = blink;
    @(posedge clk); #1 a2 = snap();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; drive(5'b0); counting = 1'b0; ring = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  int step_edge[6];
  logic [7:0] step_val[6];
  int exp_edge[6] = '{1, 11, 15, 19, 23, 27};
  logic [7:0] exp_val[6] = '{8'h58, 8'h59, 8'h00, 8'h01, 8'h02, 8'h03};
  int nsteps;
  logic [7:0] prev_sec;

  initial begin
    vecs[0]  = '{B_SS,                 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h10, P_PLAY};
    vecs[1]  = '{B_MODE,               1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 8'h10, P_NONE};
    vecs[2]  = '{B_UP,                 1'b0, 1'b0, 2'd1, 8'h01, 8'h00, 8'h10, P_NONE};
    vecs[3]  = '{B_UP,                 1'b0, 1'b0, 2'd1, 8'h02, 8'h00, 8'h10, P_NONE};
    vecs[4]  = '{B_UP,                 1'b0, 1'b0, 2'd1, 8'h03, 8'h00, 8'h10, P_NONE};
    vecs[5]  = '{B_MODE,               1'b0, 1'b0, 2'd2, 8'h03, 8'h00, 8'h10, P_NONE};
    vecs[6]  = '{B_DOWN,               1'b0, 1'b0, 2'd2, 8'h03, 8'h59, 8'h10, P_NONE};
    vecs[7]  = '{B_MODE,               1'b0, 1'b0, 2'd3, 8'h03, 8'h59, 8'h10, P_NONE};
    vecs[8]  = '{B_UP,                 1'b0, 1'b0, 2'd3, 8'h03, 8'h59, 8'h11, P_NONE};
    vecs[9]  = '{B_CONF,               1'b0, 1'b0, 2'd0, 8'h03, 8'h59, 8'h11, P_SET};
    vecs[10] = '{B_MODE,               1'b1, 1'b0, 2'd0, 8'h03, 8'h59, 8'h11, P_NONE};
    vecs[11] = '{B_SS,                 1'b1, 1'b0, 2'd0, 8'h03, 8'h59, 8'h11, P_STOP};
    vecs[12] = '{B_CONF,               1'b1, 1'b1, 2'd0, 8'h03, 8'h59, 8'h11, P_RST};
    vecs[13] = '{B_MODE,               1'b0, 1'b0, 2'd1, 8'h03, 8'h59, 8'h11, P_NONE};
    vecs[14] = '{B_MODE|B_UP|B_DOWN,   1'b0, 1'b0, 2'd2, 8'h03, 8'h59, 8'h11, P_NONE};
    vecs[15] = '{B_UP|B_DOWN,          1'b0, 1'b0, 2'd2, 8'h03, 8'h59, 8'h11, P_NONE};
    vecs[16] = '{B_CONF|B_MODE,        1'b0, 1'b0, 2'd0, 8'h03, 8'h59, 8'h11, P_SET};
    vecs[17] = '{B_CONF|B_SS,          1'b0, 1'b0, 2'd0, 8'h03, 8'h59, 8'h11, P_RST};
    vecs[18] = '{B_MODE,               1'b0, 1'b0, 2'd1, 8'h03, 8'h59, 8'h11, P_NONE};
    vecs[19] = '{B_SS,                 1'b0, 1'b0, 2'd1, 8'h03, 8'h59, 8'h11, P_NONE};
    vecs[20] = '{B_DOWN,               1'b0, 1'b0, 2'd1, 8'h02, 8'h59, 8'h11, P_NONE};
    vecs[21] = '{B_CONF,               1'b0, 1'b0, 2'd0, 8'h02, 8'h59, 8'h11, P_SET};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("reset_state", 32'(snap()), 32'(expect_snap(2'd0, 8'h00, 8'h00, 8'h10, P_NONE)));
    check("reset_blink", 32'(blink), 32'(1'b0));

    // Table-driven presses
    for (int i = 0; i < 22; i++) begin
      @(negedge clk); counting = vecs[i].cnt; ring = vecs[i].rng;
      press(vecs[i].btn, s1, s2);
      $display("vec %0d btn=%b counting=%b -> field=%0d %h:%h:%h pulses=%b", i, vecs[i].btn, vecs[i].cnt,
               s1[30:29], s1[28:21], s1[20:13], s1[12:5], s1[4:1]);
      check($sformatf("vec%0d", i), 32'(s1),
            32'(expect_snap(vecs[i].field, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].pulse)));
      check($sformatf("vec%0d_pulse_clear", i), 32'(s2),
            32'(expect_snap(vecs[i].field, vecs[i].h, vecs[i].m, vecs[i].s, P_NONE)));
    end

    // Auto-repeat in EDIT_S from 57
    do_reset();
    repeat (3) press(B_MODE, s1, s2);
    repeat (13) press(B_DOWN, s1, s2);
    $display("repeat setup: field=%0d second=%h", field_sel, second_bcd);
    check("repeat_setup", 32'({field_sel, second_bcd}), 32'({2'd3, 8'h57}));
    @(negedge clk); btn_up = 1'b1;
    prev_sec = second_bcd;
    nsteps = 0;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      if (second_bcd !== prev_sec) begin
        if (nsteps < 6) begin
          step_edge[nsteps] = k;
          step_val[nsteps] = second_bcd;
        end
        nsteps++;
        prev_sec = second_bcd;
      end
      if (k == 29) begin
        @(negedge clk); btn_up = 1'b0;
      end
    end
    check("repeat_count", 32'(nsteps), 32'(6));
    for (int i = 0; i < 6; i++) begin
      $display("repeat step %0d at edge %0d value %h", i, step_edge[i], step_val[i]);
      check($sformatf("repeat_edge%0d", i), 32'(step_edge[i]), 32'(exp_edge[i]));
      check($sformatf("repeat_val%0d", i), 32'(step_val[i]), 32'(exp_val[i]));
    end

    // Reset asserted mid-hold
    do_reset();
    press(B_MODE, s1, s2);
    repeat (5) press(B_UP, s1, s2);
    check("hour_05", 32'({field_sel, hour_bcd}), 32'({2'd1, 8'h05}));
    @(negedge clk); btn_up = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("reset mid-hold: field=%0d %h:%h:%h", field_sel, hour_bcd, minute_bcd, second_bcd);
    check("async_reset", 32'({blink, snap()}), 32'({1'b0, expect_snap(2'd0, 8'h00, 8'h00, 8'h10, P_NONE)}));
    btn_up = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("after_reset", 32'(snap()), 32'(expect_snap(2'd0, 8'h00, 8'h00, 8'h10, P_NONE)));

    // Blink phase on entering edit
    press(B_MODE, s1, s2);
    check("blink_enter", 32'(cap_blink), 32'(1'b1));
    repeat (4) @(posedge clk);
    #1 check("blink_hold", 32'(blink), 32'(1'b1));
    @(posedge clk);
    #1 check("blink_toggle", 32'(blink), 32'(1'b0));

    // Counting rising while editing abandons the edit
    press(B_UP, s1, s2);
    check("abort_setup", 32'(s1), 32'(expect_snap(2'd1, 8'h01, 8'h00, 8'h10, P_NONE)));
    @(negedge clk); counting = 1'b1;
    @(posedge clk); #1;
    $display("abort: field=%0d %h:%h:%h set=%b", field_sel, hour_bcd, minute_bcd, second_bcd, set_out);
    check("abort", 32'(snap()), 32'(expect_snap(2'd0, 8'h01, 8'h00, 8'h10, P_NONE)));
    @(posedge clk); #1;
    check("abort_no_set", 32'(snap()), 32'(expect_snap(2'd0, 8'h01, 8'h00, 8'h10, P_NONE)));
    @(negedge clk); counting = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/timer_set_editor.md
Name: timer_set_editor

Overview:
Button-driven front end for the countdown timer. It edits hour/minute/second BCD values field by field, with auto-repeat on held up/down buttons and a blink indicator for the selected field. It issues single-cycle set/play/stop/reset command pulses that the countdown timer rising-edge-detects. It sits directly upstream of the countdown timer and drives all its command and BCD preset inputs.

Parameters:
HOLD_CYCLES, 2500000, cycles up/down must stay high before auto-repeat starts (0.5 s at 5 MHz)
REPEAT_CYCLES, 500000, cycles between auto-repeat steps while held (0.1 s)
BLINK_CYCLES, 1250000, half-period of blink output in edit states

Ports:
clk  in  1  system clock, 5 MHz
rst  in  1  asynchronous, active-high reset
btn_mode  in  1  debounced level; enter edit / advance field
btn_up  in  1  debounced level; increment field
btn_down  in  1  debounced level; decrement field
btn_confirm  in  1  debounced level; commit edit, or reset timer when idle
btn_start_stop  in  1  debounced level; toggle run
counting  in  1  timer running status, from countdown timer
ring  in  1  timer expired status, from countdown timer
hour_bcd  out  8  preset hours, BCD 00-23
minute_bcd  out  8  preset minutes, BCD 00-59
second_bcd  out  8  preset seconds, BCD 00-59
field_sel  out  2  0=none, 1=hour, 2=minute, 3=second
editing  out  1  high in any edit state
blink  out  1  selected-field blink phase
set_out  out  1  one-cycle commit pulse
play_out  out  1  one-cycle start pulse
stop_out  out  1  one-cycle stop pulse
reset_out  out  1  one-cycle reload/clear-ring pulse

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. On reset: state IDLE, hour/minute/second = 8'h00/8'h00/8'h10, field_sel=0, editing=0, blink=0, all pulse outputs 0, repeat/blink counters 0, edge-detect registers 0.
- Edge detection: each button is registered once. A press is prev=0 and cur=1, and the press acts on the next clock edge.
- States: IDLE, EDIT_H, EDIT_M, EDIT_S. field_sel = 0/1/2/3 respectively. editing = (state != IDLE).
- IDLE transitions:
  - mode press with counting=0 -> EDIT_H. Ignored while counting=1.
  - start_stop press -> stop_out if counting=1, else play_out.
  - confirm press -> reset_out.
  - up/down ignored.
- EDIT transitions:
  - mode press advances H->M->S->H.
  - confirm press -> set_out, then IDLE.
  - start_stop ignored.
  - If counting rises while editing, abandon the edit: go to IDLE with no set_out. Edited values are retained on the outputs.
- Priority within one cycle: confirm > mode > up/down > start_stop. Simultaneous up and down presses, or both held, produce no step.
- Step arithmetic, BCD, selected field only:
  - up: 59->00 (minute/second), 23->00 (hour), ones 9->0 carries into tens.
  - down: 00->59 / 00->23, ones 0->9 borrows from tens.
  - Outputs are always valid BCD within range.
- Auto-repeat:
  - A press steps once immediately and clears the hold counter.
  - While the same button stays high, the counter increments. At HOLD_CYCLES-1 it steps and reloads to HOLD_CYCLES-REPEAT_CYCLES, so later steps occur every REPEAT_CYCLES.
  - Release, a field change, or leaving edit clears the counter.
- Blink: counter runs only in edit states and toggles blink every BLINK_CYCLES. On entering edit, blink=1 and the counter is cleared. In IDLE, blink=0.
- Pulse timing: each *_out is high exactly one cycle, registered, one cycle after the press is detected. At most one pulse fires per cycle.
- Output stability: BCD outputs change only in edit states, so they are stable when the downstream timer samples them 2-3 cycles after set_out.
- Reset mid-edit: immediately IDLE, values restored to 00:00:10, no pulse.

Test Plan:
1. Release rst with no buttons -> outputs 00:00:10, field_sel=0, all pulses 0. Press start_stop with counting=0 -> play_out high one cycle, 2 cycles after button rise.
2. Press mode, up x3, mode, down x1, mode, up x1, confirm -> hour=03, minute=59, second=11, set_out single pulse, field_sel back to 0.
3. HOLD_CYCLES=10, REPEAT_CYCLES=4; hold up 30 cycles in EDIT_S starting from 57 -> steps at press, +10, +14, +18, +22, +26 cycles. Values 58,59,00,01,02,03.
4. counting=1: mode press -> stays IDLE. Start_stop press -> stop_out. With ring=1, confirm press -> reset_out.
5. Mode, up and down pressed in the same cycle -> no step. Confirm and mode in the same cycle -> set_out, IDLE.
6. Editing with hour=05: assert rst mid-hold -> immediate IDLE, 00:00:10, no pulses. Separately, counting rising during edit -> IDLE, no set_out.
